// File: rtl/register_file_sb.sv
// register_file_sb: DEPTH x WIDTH register file with NUM_RD asynchronous read
// ports, one synchronous write port and a pending-write scoreboard (one busy
// bit per register plus a count of busy registers) for RAW hazard detection.
// Optional build macro SB_BYPASS_EN: same-cycle write-to-read forwarding on the
// read ports. Stored state is identical with and without the macro.
module register_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [CNT_W-1:0]         pend_cnt,
    output logic                     any_busy
);

    logic [WIDTH-1:0]  regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic              wr_ok;
    logic              rsv_ok;
    logic              same_addr;
    logic              cnt_inc;
    logic              cnt_dec;

    logic [ADDR_W-1:0] rd_a;
    logic [WIDTH-1:0]  rd_d;
    logic              rd_b;

    // Qualify strobes (register 0 is read-only when hardwired) and derive counter steps
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ok  = wr_en;
        rsv_ok = rsv_en;
        if (ZERO_REG != 0) begin
            if (wr_addr == '0)  wr_ok  = 1'b0;
            if (rsv_addr == '0) rsv_ok = 1'b0;
        end
        same_addr = (wr_addr == rsv_addr);
        // Count only real 0->1 and 1->0 transitions of busy bits.
        cnt_inc = rsv_ok && !busy[rsv_addr];
        cnt_dec = wr_ok && busy[wr_addr] && !(rsv_ok && same_addr);
    end

    // Register array: cleared by reset, written on the edge
    // NOTE: the array is reset explicitly because reads must return zero after reset;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) regs[j] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Busy bits: a write clears, a reserve sets; the reserve is assigned last so it wins on collision
    // NOTE: non-blocking assignments let the later reserve override the earlier write clear
    // to the same bit within one edge, without creating ordering races between blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_ok)  busy[wr_addr]  <= 1'b0;
            if (rsv_ok) busy[rsv_addr] <= 1'b1;
        end
    end

    // Pending counter: tracks the number of set busy bits, never wraps by construction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_cnt <= pend_cnt + CNT_W'(1);
                2'b01:   pend_cnt <= pend_cnt - CNT_W'(1);
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    assign any_busy = (pend_cnt != '0);

    // Combinational read ports, optionally forwarding the in-flight write, forced to zero in reset
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_a    = '0;
        rd_d    = '0;
        rd_b    = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_a = rd_addr[i*ADDR_W +: ADDR_W];
            rd_d = regs[rd_a];
            rd_b = busy[rd_a];
`ifdef SB_BYPASS_EN
            if (wr_ok && (wr_addr == rd_a)) begin
                rd_d = wr_data;
                rd_b = rsv_ok && same_addr;
            end
`else
`endif
            if (rst) begin
                rd_d = '0;
                rd_b = 1'b0;
            end
            rd_data[i*WIDTH +: WIDTH] = rd_d;
            rd_busy[i]                = rd_b;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed test of register_file_sb in the default
// configuration and in a 64-bit / 16-entry / 3-port / no-zero-register variant.
module tb_register_file_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance signals
    logic        wr_en, rsv_en;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [5:0]  pend_cnt;
    logic        any_busy;

    // Wide instance signals
    logic         w_wr_en, w_rsv_en;
    logic [3:0]   w_wr_addr, w_rsv_addr;
    logic [63:0]  w_wr_data;
    logic [11:0]  w_rd_addr;
    logic [191:0] w_rd_data;
    logic [2:0]   w_rd_busy;
    logic [4:0]   w_pend_cnt;
    logic         w_any_busy;

    int n_checks = 0;
    int n_fail   = 0;

    register_file_sb u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .pend_cnt (pend_cnt),
        .any_busy (any_busy)
    );

    register_file_sb #(
        .WIDTH    (64),
        .DEPTH    (16),
        .NUM_RD   (3),
        .ZERO_REG (0)
    ) u_wide (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data),
        .rsv_en   (w_rsv_en),
        .rsv_addr (w_rsv_addr),
        .rd_addr  (w_rd_addr),
        .rd_data  (w_rd_data),
        .rd_busy  (w_rd_busy),
        .pend_cnt (w_pend_cnt),
        .any_busy (w_any_busy)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        idle();
        wr_addr  = '0; wr_data = '0; rsv_addr = '0; rd_addr = '0;
        w_wr_en  = 1'b0; w_rsv_en = 1'b0;
        w_wr_addr = '0; w_wr_data = '0; w_rsv_addr = '0; w_rd_addr = '0;

        // Reset state
        #3;
        check("reset_rd_data", 192'(rd_data), 192'(64'h0));
        check("reset_pend_cnt", 192'(pend_cnt), 192'(6'd0));
        check("reset_any_busy", 192'(any_busy), 192'(1'b0));
        tick();
        rst = 1'b0;

        // Write r5, reserve r6, then assert reset mid-stream
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rsv_en = 1'b1; rsv_addr = 5'd6;
        tick();
        idle();
        rd_addr = {5'd6, 5'd5};
        #1;
        check("r5_written", 192'(rd_data[31:0]), 192'(32'hDEADBEEF));
        check("r6_busy", 192'(rd_busy), 192'(2'b10));
        check("pend_after_rsv", 192'(pend_cnt), 192'(6'd1));
        rst = 1'b1;
        #1;
        check("rst_async_rd_data", 192'(rd_data), 192'(64'h0));
        check("rst_async_rd_busy", 192'(rd_busy), 192'(2'b00));
        check("rst_async_pend", 192'(pend_cnt), 192'(6'd0));
        rst = 1'b0;
        #1;
        check("r5_cleared", 192'(rd_data), 192'(64'h0));

        // Register 0 ignores writes and reserves
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        rd_addr = {5'd0, 5'd0};
        #1;
        check("r0_reads_zero", 192'(rd_data), 192'(64'h0));
        check("r0_not_busy", 192'(rd_busy), 192'(2'b00));
        check("r0_pend", 192'(pend_cnt), 192'(6'd0));

        // Write latency on r7, both ports
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_addr = {5'd7, 5'd7};
        #2;
`ifdef SB_BYPASS_EN
        check("r7_same_cycle", 192'(rd_data), 192'(64'hA5A5A5A5_A5A5A5A5));
`else
        check("r7_same_cycle", 192'(rd_data), 192'(64'h0));
`endif
        check("r7_same_busy", 192'(rd_busy), 192'(2'b00));
        tick();
        idle();
        check("r7_next_cycle", 192'(rd_data), 192'(64'hA5A5A5A5_A5A5A5A5));

        // Scoreboard: reserve r3, r4, r3
        rd_addr = {5'd4, 5'd3};
        rsv_en = 1'b1; rsv_addr = 5'd3;
        tick();
        check("pend_1", 192'(pend_cnt), 192'(6'd1));
        rsv_addr = 5'd4;
        tick();
        check("pend_2", 192'(pend_cnt), 192'(6'd2));
        rsv_addr = 5'd3;
        tick();
        check("pend_2_again", 192'(pend_cnt), 192'(6'd2));
        check("r3_r4_busy", 192'(rd_busy), 192'(2'b11));
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
        #2;
`ifdef SB_BYPASS_EN
        check("r3_same_data", 192'(rd_data[31:0]), 192'(32'h77));
        check("r3_same_busy", 192'(rd_busy), 192'(2'b10));
`else
        check("r3_same_data", 192'(rd_data[31:0]), 192'(32'h0));
        check("r3_same_busy", 192'(rd_busy), 192'(2'b11));
`endif
        tick();
        check("pend_after_w3", 192'(pend_cnt), 192'(6'd1));
        check("r3_clear_busy", 192'(rd_busy), 192'(2'b10));
        check("any_busy_1", 192'(any_busy), 192'(1'b1));
        check("r3_data", 192'(rd_data[31:0]), 192'(32'h77));
        wr_addr = 5'd4; wr_data = 32'h44;
        tick();
        idle();
        check("pend_after_w4", 192'(pend_cnt), 192'(6'd0));
        check("any_busy_0", 192'(any_busy), 192'(1'b0));

        // Collision on r9
        rd_addr = {5'd10, 5'd9};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        check("pend_r9", 192'(pend_cnt), 192'(6'd1));
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        #2;
`ifdef SB_BYPASS_EN
        check("collide_same_data", 192'(rd_data[31:0]), 192'(32'h55));
`else
        check("collide_same_data", 192'(rd_data[31:0]), 192'(32'h0));
`endif
        check("collide_same_busy", 192'(rd_busy), 192'(2'b01));
        tick();
        check("collide_data", 192'(rd_data[31:0]), 192'(32'h55));
        check("collide_busy", 192'(rd_busy), 192'(2'b01));
        check("collide_pend", 192'(pend_cnt), 192'(6'd1));
        // Write r9 and reserve r10 together: net zero
        wr_addr = 5'd9; wr_data = 32'h99; rsv_addr = 5'd10;
        tick();
        idle();
        check("diff_addr_pend", 192'(pend_cnt), 192'(6'd1));
        check("diff_addr_busy", 192'(rd_busy), 192'(2'b10));
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h10;
        tick();
        idle();
        check("r10_release", 192'(pend_cnt), 192'(6'd0));

        // Full scoreboard
        for (int i = 1; i < 32; i++) begin
            rsv_en = 1'b1; rsv_addr = 5'(i);
            tick();
        end
        check("full_pend_31", 192'(pend_cnt), 192'(6'd31));
        rsv_addr = 5'd0;
        tick();
        rsv_addr = 5'd5;
        tick();
        idle();
        check("full_no_wrap", 192'(pend_cnt), 192'(6'd31));
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
            tick();
        end
        idle();
        rd_addr = {5'd31, 5'd1};
        #1;
        check("full_drained", 192'(pend_cnt), 192'(6'd0));
        check("full_data", 192'(rd_data), 192'(64'h1F1F1F1F_01010101));
        check("full_busy", 192'(rd_busy), 192'(2'b00));

        // Wide variant: r0 is an ordinary register
        w_wr_en = 1'b1; w_wr_addr = 4'd0; w_wr_data = 64'hFFFF_FFFF_0000_0001;
        w_rd_addr = 12'h000;
        tick();
        w_wr_en = 1'b0;
        check("wide_r0_data", w_rd_data, {3{64'hFFFF_FFFF_0000_0001}});
        check("wide_pend_0", 192'(w_pend_cnt), 192'(5'd0));
        w_rsv_en = 1'b1; w_rsv_addr = 4'd0;
        tick();
        w_rsv_en = 1'b0;
        check("wide_pend_1", 192'(w_pend_cnt), 192'(5'd1));
        check("wide_busy", 192'(w_rd_busy), 192'(3'b111));
        check("wide_any_busy", 192'(w_any_busy), 192'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
